// File: rtl/net_rx_pcie_bridge.sv
// Store-and-forward bridge from the router user rx channel to the PCIe slot DMA output.
// Optional statistics counters are enabled by defining NET_RX_PCIE_STATS_EN.
module net_rx_pcie_bridge #(
  parameter int DEPTH         = 64,
  parameter int MAX_PKT_WORDS = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [127:0]           rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_last,
  output logic                   rx_ready,
  input  logic [15:0]            cfg_slot,
  output logic [127:0]           pcie_out_data,
  output logic [15:0]            pcie_out_slot,
  output logic [3:0]             pcie_out_pad,
  output logic                   pcie_out_last,
  output logic                   pcie_out_valid,
  input  logic                   pcie_grant_in,
  input  logic                   err_clr,
  output logic                   oversize_err,
`ifdef NET_RX_PCIE_STATS_EN
  output logic [31:0]            pkt_count_out,
  output logic [31:0]            word_count_out,
  output logic [31:0]            drop_count_out,
`endif
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   WCNT_LAST = (AW+1)'(MAX_PKT_WORDS - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  if (MAX_PKT_WORDS > DEPTH) begin : g_chk_max
    $error("net_rx_pcie_bridge: MAX_PKT_WORDS must not exceed DEPTH");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("net_rx_pcie_bridge: DEPTH must be a power of 2 and at least 4");
  end

  typedef enum logic {IDLE, SEND} state_t;

  logic [128:0]   r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_level;
  logic [AW:0]    r_pkt_avail;
  logic [AW:0]    r_wcnt;
  logic           r_drop;
  logic           r_avail_q;
  state_t         r_state;

  logic           w_full;
  logic           w_rx_xfer;
  logic           w_store;
  logic           w_oversize;
  logic           w_store_last;
  logic           w_out_xfer;
  logic           w_pkt_done;
  logic           w_pop;
  logic [128:0]   w_head;

  assign w_full       = (r_level == LVL_FULL);
  assign rx_ready     = !w_full | r_drop;
  assign w_rx_xfer    = rx_valid & rx_ready;
  assign w_store      = w_rx_xfer & !r_drop;
  assign w_oversize   = w_store & (r_wcnt == WCNT_LAST) & !rx_last;
  assign w_store_last = w_store & (rx_last | w_oversize);
  assign w_out_xfer   = pcie_out_valid & pcie_grant_in;
  assign w_pkt_done   = w_out_xfer & pcie_out_last;
  assign w_head       = r_mem[r_rptr];
  assign pcie_out_pad = 4'd0;
  assign fifo_level   = r_level;

  // A new packet is only started once the avail count has been nonzero for a full cycle.
  assign w_pop = ((r_state == IDLE) && r_avail_q && (r_pkt_avail != '0)) ||
                 ((r_state == SEND) && w_out_xfer && !pcie_out_last);

  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wptr] <= {rx_data, rx_last | w_oversize};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr       <= '0;
      r_wcnt       <= '0;
      r_drop       <= 1'b0;
      oversize_err <= 1'b0;
    end else begin
      if (w_store) r_wptr <= r_wptr + PTR_ONE;
      if (w_store_last)  r_wcnt <= '0;
      else if (w_store)  r_wcnt <= r_wcnt + LVL_ONE;
      if (w_oversize)                        r_drop <= 1'b1;
      else if (r_drop && w_rx_xfer && rx_last) r_drop <= 1'b0;
      if (w_oversize)   oversize_err <= 1'b1;
      else if (err_clr) oversize_err <= 1'b0;
    end
  end

  // fifo_level includes the word held in the output register until the sink takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level     <= '0;
      r_pkt_avail <= '0;
      r_avail_q   <= 1'b0;
    end else begin
      case ({w_store, w_out_xfer})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      case ({w_store_last, w_pkt_done})
        2'b10:   r_pkt_avail <= r_pkt_avail + LVL_ONE;
        2'b01:   r_pkt_avail <= r_pkt_avail - LVL_ONE;
        default: r_pkt_avail <= r_pkt_avail;
      endcase
      r_avail_q <= (r_pkt_avail != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_rptr         <= '0;
      pcie_out_data  <= '0;
      pcie_out_last  <= 1'b0;
      pcie_out_slot  <= '0;
      pcie_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            {pcie_out_data, pcie_out_last} <= w_head;
            pcie_out_slot  <= cfg_slot;
            pcie_out_valid <= 1'b1;
            r_rptr         <= r_rptr + PTR_ONE;
            r_state        <= SEND;
          end
        end
        SEND: begin
          if (w_pop) begin
            {pcie_out_data, pcie_out_last} <= w_head;
            r_rptr <= r_rptr + PTR_ONE;
          end else if (w_pkt_done) begin
            pcie_out_valid <= 1'b0;
            pcie_out_last  <= 1'b0;
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef NET_RX_PCIE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count_out  <= '0;
      word_count_out <= '0;
      drop_count_out <= '0;
    end else begin
      if (w_pkt_done)          pkt_count_out  <= pkt_count_out + 32'd1;
      if (w_out_xfer)          word_count_out <= word_count_out + 32'd1;
      if (r_drop && w_rx_xfer) drop_count_out <= drop_count_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_net_rx_pcie_bridge.sv
// Directed testbench for net_rx_pcie_bridge (DEPTH=64, MAX_PKT_WORDS=4).
// Also checks the statistics outputs when NET_RX_PCIE_STATS_EN is defined.
module tb_net_rx_pcie_bridge;

  logic         clk;
  logic         rst;
  logic [127:0] rx_data;
  logic         rx_valid;
  logic         rx_last;
  logic         rx_ready;
  logic [15:0]  cfg_slot;
  logic [127:0] pcie_out_data;
  logic [15:0]  pcie_out_slot;
  logic [3:0]   pcie_out_pad;
  logic         pcie_out_last;
  logic         pcie_out_valid;
  logic         pcie_grant_in;
  logic         err_clr;
  logic         oversize_err;
  logic [6:0]   fifo_level;
`ifdef NET_RX_PCIE_STATS_EN
  logic [31:0]  pkt_count_out;
  logic [31:0]  word_count_out;
  logic [31:0]  drop_count_out;
`endif

  net_rx_pcie_bridge #(.DEPTH(64), .MAX_PKT_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
    .cfg_slot(cfg_slot),
    .pcie_out_data(pcie_out_data), .pcie_out_slot(pcie_out_slot), .pcie_out_pad(pcie_out_pad),
    .pcie_out_last(pcie_out_last), .pcie_out_valid(pcie_out_valid), .pcie_grant_in(pcie_grant_in),
    .err_clr(err_clr), .oversize_err(oversize_err),
`ifdef NET_RX_PCIE_STATS_EN
    .pkt_count_out(pkt_count_out), .word_count_out(word_count_out), .drop_count_out(drop_count_out),
`endif
    .fifo_level(fifo_level)
  );

  typedef struct {
    logic [127:0] d;
    logic         last;
    logic [15:0]  slot;
    int           c;
  } rec_t;

  rec_t q[$];
  rec_t mRec;
  int   cyc = 0;
  int   padBad = 0;
  int   totalChecks = 0;
  int   badChecks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Each record is a word the sink takes on the next rising edge, stamped with the edge count so far.
  always @(negedge clk) begin
    if (!rst && pcie_out_valid && pcie_grant_in) begin
      mRec.d    = pcie_out_data;
      mRec.last = pcie_out_last;
      mRec.slot = pcie_out_slot;
      mRec.c    = cyc;
      q.push_back(mRec);
    end
    if (pcie_out_pad != 4'd0) padBad++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitSteps(input int n);
    repeat (n) step();
  endtask

  task automatic applyStimulus(input logic [127:0] d, input logic last, output int acc);
    int n;
    n = 0;
    rx_data  = d;
    rx_last  = last;
    rx_valid = 1'b1;
    while (!rx_ready && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) checkOutput("rx_accept_timeout", 0, 1);
    acc = cyc + 1;
    step();
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (!pcie_out_valid && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) checkOutput({tag, "_valid_timeout"}, 0, 1);
  endtask

  task automatic waitRecords(input string tag, input int k);
    int n;
    n = 0;
    while (q.size() < k && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) checkOutput({tag, "_rec_timeout"}, q.size(), k);
  endtask

  task automatic checkRec(input string tag, input int idx, input logic [127:0] d,
                          input logic last, input logic [15:0] slot);
    if (idx < q.size()) begin
      checkOutput({tag, "_data"}, q[idx].d, d);
      checkOutput({tag, "_last"}, q[idx].last, last);
      checkOutput({tag, "_slot"}, q[idx].slot, slot);
    end else begin
      checkOutput({tag, "_missing"}, 0, 1);
    end
  endtask

  task automatic checkCyc(input string tag, input int idx, input int exp);
    if (idx < q.size()) checkOutput(tag, q[idx].c, exp);
    else                checkOutput({tag, "_missing"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", totalChecks, badChecks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a;
    int accC;
    int accX;
    logic [127:0] hd;
    logic hv;
    logic hg;

    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_last = 1'b0;
    cfg_slot = '0; pcie_grant_in = 1'b0; err_clr = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_valid", pcie_out_valid, 0);
    checkOutput("rst_data",  pcie_out_data, 0);
    checkOutput("rst_slot",  pcie_out_slot, 0);
    checkOutput("rst_last",  pcie_out_last, 0);
    checkOutput("rst_pad",   pcie_out_pad, 0);
    checkOutput("rst_err",   oversize_err, 0);
    checkOutput("rst_level", fifo_level, 0);
    step();
    rst = 1'b0;
    step();

    // Single 3-word packet, grant held high
    $display("[TB] single packet");
    pcie_grant_in = 1'b1; cfg_slot = 16'h0005;
    applyStimulus(128'hA, 1'b0, a);
    applyStimulus(128'hB, 1'b0, a);
    applyStimulus(128'hC, 1'b1, accC);
    waitSteps(10);
    checkOutput("t1_count", q.size(), 3);
    checkRec("t1_w0", 0, 128'hA, 1'b0, 16'h0005);
    checkRec("t1_w1", 1, 128'hB, 1'b0, 16'h0005);
    checkRec("t1_w2", 2, 128'hC, 1'b1, 16'h0005);
    checkCyc("t1_first_valid", 0, accC + 2);
    checkCyc("t1_cyc1", 1, accC + 3);
    checkCyc("t1_cyc2", 2, accC + 4);
    checkOutput("t1_level", fifo_level, 0);
    q.delete();

    // Backpressure with alternating grant
    $display("[TB] backpressure");
    pcie_grant_in = 1'b0; cfg_slot = 16'h0007;
    applyStimulus(128'h10, 1'b0, a);
    applyStimulus(128'h11, 1'b0, a);
    applyStimulus(128'h12, 1'b0, a);
    applyStimulus(128'h13, 1'b1, a);
    waitValid("t2");
    for (int i = 0; i < 16; i++) begin
      pcie_grant_in = (i % 2 == 0);
      hd = pcie_out_data; hv = pcie_out_valid; hg = pcie_grant_in;
      step();
      if (hv && !hg) checkOutput("t2_hold", pcie_out_data, hd);
    end
    pcie_grant_in = 1'b1;
    waitSteps(4);
    checkOutput("t2_count", q.size(), 4);
    checkRec("t2_w0", 0, 128'h10, 1'b0, 16'h0007);
    checkRec("t2_w1", 1, 128'h11, 1'b0, 16'h0007);
    checkRec("t2_w2", 2, 128'h12, 1'b0, 16'h0007);
    checkRec("t2_w3", 3, 128'h13, 1'b1, 16'h0007);
    checkOutput("t2_level", fifo_level, 0);
    q.delete();

    // Fill the buffer with 64 one-word packets, then drain
    $display("[TB] full buffer");
    pcie_grant_in = 1'b0; cfg_slot = 16'h0003;
    for (int i = 0; i < 64; i++) applyStimulus(128'h100 + 128'(i), 1'b1, a);
    checkOutput("t3_rx_ready", rx_ready, 0);
    checkOutput("t3_level", fifo_level, 64);
    checkOutput("t3_pkt_avail", dut.r_pkt_avail, 64);
    pcie_grant_in = 1'b1;
    waitSteps(140);
    checkOutput("t3_count", q.size(), 64);
    for (int i = 0; i < 64; i++) begin
      checkRec($sformatf("t3_p%0d", i), i, 128'h100 + 128'(i), 1'b1, 16'h0003);
      if (i > 0 && i < q.size()) checkOutput($sformatf("t3_gap%0d", i), q[i].c - q[i-1].c, 2);
    end
    checkOutput("t3_level_end", fifo_level, 0);
    checkOutput("t3_rx_ready_end", rx_ready, 1);
    q.delete();

    // Oversize packet truncated to 4 words, tail dropped
    $display("[TB] oversize");
    pcie_grant_in = 1'b1; cfg_slot = 16'h0009;
    for (int i = 0; i < 7; i++) applyStimulus(128'h20 + 128'(i), (i == 6), a);
    applyStimulus(128'h30, 1'b0, a);
    applyStimulus(128'h31, 1'b1, a);
    waitSteps(12);
    checkOutput("t4_count", q.size(), 6);
    checkRec("t4_w0", 0, 128'h20, 1'b0, 16'h0009);
    checkRec("t4_w1", 1, 128'h21, 1'b0, 16'h0009);
    checkRec("t4_w2", 2, 128'h22, 1'b0, 16'h0009);
    checkRec("t4_w3", 3, 128'h23, 1'b1, 16'h0009);
    checkRec("t4_w4", 4, 128'h30, 1'b0, 16'h0009);
    checkRec("t4_w5", 5, 128'h31, 1'b1, 16'h0009);
    checkOutput("t4_err_set", oversize_err, 1);
    checkOutput("t4_level", fifo_level, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("t4_err_clr", oversize_err, 0);
`ifdef NET_RX_PCIE_STATS_EN
    checkOutput("t4_drop_count", drop_count_out, 3);
    checkOutput("t4_pkt_count", pkt_count_out, 68);
    checkOutput("t4_word_count", word_count_out, 77);
`endif
    q.delete();

    // Last word of packet 1 leaves while last word of packet 2 is stored
    $display("[TB] simultaneous");
    pcie_grant_in = 1'b0; cfg_slot = 16'h000C;
    applyStimulus(128'h40, 1'b0, a);
    applyStimulus(128'h41, 1'b1, a);
    waitValid("t5");
    pcie_grant_in = 1'b1;
    applyStimulus(128'h50, 1'b0, a);
    applyStimulus(128'h51, 1'b1, accX);
    checkOutput("t5_pkt_avail", dut.r_pkt_avail, 1);
    waitSteps(8);
    checkOutput("t5_count", q.size(), 4);
    checkRec("t5_w0", 0, 128'h40, 1'b0, 16'h000C);
    checkRec("t5_w1", 1, 128'h41, 1'b1, 16'h000C);
    checkRec("t5_w2", 2, 128'h50, 1'b0, 16'h000C);
    checkRec("t5_w3", 3, 128'h51, 1'b1, 16'h000C);
    checkCyc("t5_p1_end", 1, accX - 1);
    checkCyc("t5_p2_start", 2, accX + 1);
    q.delete();

    // Async reset in the middle of a packet
    $display("[TB] reset mid-send");
    pcie_grant_in = 1'b1; cfg_slot = 16'h000D;
    for (int i = 0; i < 4; i++) applyStimulus(128'h60 + 128'(i), (i == 3), a);
    q.delete();
    waitRecords("t6", 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_valid", pcie_out_valid, 0);
    checkOutput("t6_data",  pcie_out_data, 0);
    checkOutput("t6_last",  pcie_out_last, 0);
    checkOutput("t6_slot",  pcie_out_slot, 0);
    checkOutput("t6_level", fifo_level, 0);
    step();
    step();
    rst = 1'b0;
    q.delete();
    cfg_slot = 16'h000B;
    applyStimulus(128'h70, 1'b1, a);
    waitSteps(6);
    checkOutput("t6_count", q.size(), 1);
    checkRec("t6_w0", 0, 128'h70, 1'b1, 16'h000B);
    checkOutput("t6_level_end", fifo_level, 0);
    checkOutput("pad_always_zero", padBad, 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
